// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: tags each sampled pixel with recovered
// coordinates, validates line/frame periods and tracks lock.
module vga_sync_decoder #(
  parameter int unsigned H_DISPLAY    = 640,
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned H_SYNC_START = 656,
  parameter int unsigned V_DISPLAY    = 480,
  parameter int unsigned V_TOTAL      = 525,
  parameter int unsigned V_SYNC_START = 490,
  parameter int unsigned LOCK_FRAMES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [5:0] rgb_in,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       display_on,
  output logic [5:0] pix_out,
  output logic       frame_start,
  output logic       locked,
  output logic [7:0] err_count
);

  localparam logic [9:0] HD      = 10'(H_DISPLAY);
  localparam logic [9:0] HT_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] HSS     = 10'(H_SYNC_START);
  localparam logic [9:0] VD      = 10'(V_DISPLAY);
  localparam logic [9:0] VT_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] VSS     = 10'(V_SYNC_START);
  localparam logic [3:0] LF      = 4'(LOCK_FRAMES);
  localparam logic [7:0] ERR_MAX = 8'hFF;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    LINE   = 2'd1,
    FRAME  = 2'd2,
    LOCKED = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] good_frames, good_nxt;
  logic [7:0] err_nxt;

  logic       hs_s1, vs_s1, hs_prev, vs_prev;
  logic [5:0] rgb_s1;
  logic [9:0] h_cnt, v_cnt;

  logic       h_edge, v_edge, bad;
  logic [9:0] h_tag, v_tag, h_nxt, v_nxt;
  logic       in_lock_c, disp_c, fs_c;

  // Stage 1: input capture plus free-running position of the captured sample
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_s1   <= 1'b0;
      vs_s1   <= 1'b0;
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
      rgb_s1  <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      hs_s1   <= hsync_in;
      vs_s1   <= vsync_in;
      hs_prev <= hs_s1;
      vs_prev <= vs_s1;
      rgb_s1  <= rgb_in;
      h_cnt   <= h_nxt;
      v_cnt   <= v_nxt;
    end
  end

  assign h_edge = hs_prev & ~hs_s1;
  assign v_edge = vs_prev & ~vs_s1;

  // Realigned tag of the stage-1 sample and the counter value for the next one
  always_comb begin
    h_tag = h_cnt;
    v_tag = v_cnt;
    h_nxt = '0;
    v_nxt = '0;
    if (v_edge) begin
      h_tag = '0;
      v_tag = VSS;
    end
    if (h_edge) h_tag = HSS;
    bad = (h_edge && (h_cnt != HSS)) ||
          (v_edge && !((h_cnt == 10'd0) && (v_cnt == VSS)));
    if (h_tag == HT_LAST) begin
      h_nxt = '0;
      v_nxt = (v_tag == VT_LAST) ? 10'd0 : v_tag + 10'd1;
    end else begin
      h_nxt = h_tag + 10'd1;
      v_nxt = v_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HUNT;
      good_frames <= '0;
    end else begin
      state       <= state_nxt;
      good_frames <= good_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    good_nxt  = good_frames;
    err_nxt   = err_count;
    case (state)
      HUNT:   if (h_edge) state_nxt = LINE;
      LINE: begin
        if (v_edge) begin
          state_nxt = FRAME;
          good_nxt  = '0;
        end
      end
      FRAME: begin
        if (bad) begin
          state_nxt = HUNT;
        end else if (v_edge) begin
          good_nxt = good_frames + 4'd1;
          if (good_frames + 4'd1 == LF) state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (bad) begin
          state_nxt = HUNT;
          if (err_count != ERR_MAX) err_nxt = err_count + 8'd1;
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  // Display qualifiers follow the lock state seen by the stage-1 sample
  always_comb begin
    in_lock_c = (state == LOCKED);
    disp_c    = in_lock_c && (h_tag < HD) && (v_tag < VD);
    fs_c      = in_lock_c && (h_tag == 10'd0) && (v_tag == 10'd0);
  end

  // Stage 2: registered pixel, coordinates and status
  always_ff @(posedge clk) begin
    if (reset) begin
      hpos        <= '0;
      vpos        <= '0;
      display_on  <= 1'b0;
      pix_out     <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      err_count   <= '0;
    end else begin
      hpos        <= h_tag;
      vpos        <= v_tag;
      display_on  <= disp_c;
      pix_out     <= disp_c ? rgb_s1 : 6'd0;
      frame_start <= fs_c;
      locked      <= in_lock_c;
      err_count   <= err_nxt;
    end
  end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart to the VGA timing/pixel generator: samples a 640x480@60 VGA stream of hsync, vsync and 2-bit RGB on the system clock.
- Recovers per-pixel coordinates, validates line and frame periods, and declares lock.
- Outputs the registered pixel with its coordinates.
- Used for loopback self-test of the VGA output path and for capture of external VGA sources clocked at the pixel rate.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_TOTAL, 800, clocks per line
H_SYNC_START, 656, h coordinate of hsync leading edge
V_DISPLAY, 480, visible lines per frame
V_TOTAL, 525, lines per frame
V_SYNC_START, 490, v coordinate of vsync leading edge
LOCK_FRAMES, 2, consecutive good frames required to assert locked (1..15)

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high reset
hsync_in  in  1  hsync, active low
vsync_in  in  1  vsync, active low
rgb_in  in  6  {R[1:0],G[1:0],B[1:0]}
hpos  out  10  recovered x of pix_out
vpos  out  10  recovered y of pix_out
display_on  out  1  locked and hpos<H_DISPLAY and vpos<V_DISPLAY
pix_out  out  6  registered rgb_in; 0 when display_on=0
frame_start  out  1  one-cycle pulse with hpos=0, vpos=0 while locked
locked  out  1  timing lock
err_count  out  8  saturating count of timing violations

Behaviour:
Clock and reset:
- One clock; reset is synchronous and active-high.
- Reset clears all registers; every output reads 0 in the cycle after reset is sampled high; state = HUNT.
- Reset asserted mid-frame is honoured the same way. Lock must be re-acquired from scratch.

Pipeline (2 cycles, inputs to outputs):
- Stage 1 registers hsync_in, vsync_in, rgb_in and keeps the previous stage-1 sync values.
- Stage 2 registers pix_out, hpos, vpos, display_on, frame_start from stage 1.

Edge detection (in stage 1):
- Leading edge = previous sync sample 1, current sample 0.

Counters:
- h_cnt, v_cnt (10-bit) tag the stage-1 sample.
- Free-running: h_cnt increments each cycle and wraps H_TOTAL-1 -> 0. v_cnt increments on that wrap and wraps V_TOTAL-1 -> 0.
- On an hsync leading edge, the sample is assigned h=H_SYNC_START.
- On a vsync leading edge, the sample is assigned h=0, v=V_SYNC_START.

Checks:
- Line check: on an hsync edge, the free-running h_cnt must already equal H_SYNC_START.
- Frame check: on a vsync edge, h_cnt must equal 0 and v_cnt must equal V_SYNC_START.

State machine:
- HUNT: on first hsync edge, realign h -> LINE. No checks in this state.
- LINE: hsync edges realign h and are line-checked. A failure realigns and stays in LINE (no error count). First vsync edge realigns h/v, clears good_frames -> FRAME.
- FRAME: both checks active. A passed frame check increments good_frames (4-bit). When good_frames reaches LOCK_FRAMES -> LOCKED. Any failed check -> HUNT with realignment.
- LOCKED: both checks active. A failed check increments err_count (saturates at 255), drops locked, realigns, -> HUNT.
- Simultaneous hsync and vsync edges in one sample: both realignments are applied (v from vsync, h=H_SYNC_START from hsync). Frame check fails because h≠0 at a vsync edge.

Output rules:
- locked is registered: 1 from the cycle after entering LOCKED; 0 in all other states.
- display_on and frame_start follow the locked state of the stage-1 sample they belong to.
- pix_out = 0 whenever display_on = 0.
- hpos/vpos are valid and driven in all states (garbage before alignment, but stay in range).
- err_count is never cleared except by reset.

Test Plan:
- Drive a stream from a reference 640x480 generator model (pixel = h^v low 6 bits), LOCK_FRAMES=2 -> locked rises during 3rd frame after the first vsync edge. After lock, pix_out, hpos, vpos match the model delayed 2 cycles for every visible pixel. frame_start pulses once per 420000 cycles. err_count=0.
- After lock, stretch one line to 801 clocks -> at the next hsync edge locked falls, err_count=1, state HUNT. Re-lock 2 good frames later.
- Sync inputs held at 1 for 2 full frames after reset -> locked=0, display_on=0, pix_out=0, err_count=0.
- Locked stream, reset pulsed high for 1 cycle at v=200, h=300 -> outputs all 0 the next cycle. Lock re-acquired only after a fresh vsync plus 2 good frames.
- Locked stream with vsync edge moved to v=491 -> frame check fails. Repeat 300 times -> err_count saturates at 255.
- Inject hsync and vsync leading edges in the same sample while in FRAME -> state returns to HUNT, no err_count increment.
